// File: rtl/div_issue_seq_pkg.sv
// Shared types for the divide issue sequencer: branch tags, request
// entries, FSM states and the branch-kill match function.
package rv32i_types;

  localparam int BR_TAG_W      = 4;
  localparam int DIV_XLEN      = 32;
  localparam int DIV_ROB_IDX_W = 5;

  // Branch mask carried by every in-flight op; the sign selects how the
  // mask is compared against a mispredicted branch.
  typedef struct packed {
    logic                sign;
    logic [BR_TAG_W-1:0] tag;
  } branch_tag_t;

  localparam logic division_op  = 1'b0;
  localparam logic remainder_op = 1'b1;

  typedef struct packed {
    logic [DIV_XLEN-1:0]      a;
    logic [DIV_XLEN-1:0]      b;
    logic                     op;
    logic [DIV_ROB_IDX_W-1:0] rob_idx;
    branch_tag_t              br_tag;
    logic                     valid;
  } div_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD
  } div_state_e;

  // True when an op tagged entry_tag must die on a flush of flush_tag.
  function automatic logic br_killed(branch_tag_t entry_tag, branch_tag_t flush_tag);
    if (entry_tag.sign == flush_tag.sign) begin
      return (entry_tag.tag & flush_tag.tag) == flush_tag.tag;
    end
    return (entry_tag.tag & flush_tag.tag) == entry_tag.tag;
  endfunction

endpackage

// File: rtl/div_issue_seq_if.sv
// Dispatch, divider and CDB signals of the divide issue sequencer.
// master: the sequencer itself; slave: dispatch, divider and CDB side.
interface div_issue_seq_if
  import rv32i_types::*;
#(
  parameter int XLEN      = DIV_XLEN,
  parameter int ROB_IDX_W = DIV_ROB_IDX_W
) ();

  logic                 enq_valid;
  logic                 enq_ready;
  logic [XLEN-1:0]      enq_a;
  logic [XLEN-1:0]      enq_b;
  logic                 enq_op;
  logic [ROB_IDX_W-1:0] enq_rob_idx;
  branch_tag_t          enq_br_tag;

  logic                 flush;
  branch_tag_t          flush_tag;

  logic                 div_start;
  logic [XLEN-1:0]      div_a;
  logic [XLEN-1:0]      div_b;
  logic                 div_type;
  branch_tag_t          div_br_tag;
  logic                 div_busy;
  logic                 div_done;
  logic [XLEN-1:0]      div_result;
  logic                 div_result_taken;

  logic                 cdb_valid;
  logic                 cdb_ready;
  logic [XLEN-1:0]      cdb_data;
  logic [ROB_IDX_W-1:0] cdb_rob_idx;

  modport master (
    input  enq_valid, enq_a, enq_b, enq_op, enq_rob_idx, enq_br_tag,
    input  flush, flush_tag,
    input  div_busy, div_done, div_result,
    input  cdb_ready,
    output enq_ready,
    output div_start, div_a, div_b, div_type, div_br_tag, div_result_taken,
    output cdb_valid, cdb_data, cdb_rob_idx
  );

  modport slave (
    output enq_valid, enq_a, enq_b, enq_op, enq_rob_idx, enq_br_tag,
    output flush, flush_tag,
    output div_busy, div_done, div_result,
    output cdb_ready,
    input  enq_ready,
    input  div_start, div_a, div_b, div_type, div_br_tag, div_result_taken,
    input  cdb_valid, cdb_data, cdb_rob_idx
  );

endinterface

// File: rtl/div_req_fifo.sv
// Circular request FIFO for divide ops. Flushed entries are invalidated in
// place and the head steps over one invalid entry per cycle.
module div_req_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enq_valid_i,
  input  div_req_t    enq_req_i,
  output logic        enq_ready_o,
  input  logic        flush_i,
  input  branch_tag_t flush_tag_i,
  input  logic        deq_i,
  output div_req_t    head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  div_req_t         mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq_ready_q;
  logic             push, pop, skip, head_kill;
  div_req_t         head_entry;

  // Head presentation, push/pop decisions and next pointers.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, starting with these defaults, so no latch is inferred.
    head_entry   = mem_q[head_q];
    head_kill    = flush_i && br_killed(head_entry.br_tag, flush_tag_i);
    skip         = (count_q != '0) && !valid_q[head_q];
    head_o       = head_entry;
    head_o.valid = (count_q != '0) && valid_q[head_q] && !head_kill;
    push         = enq_valid_i && enq_ready_q &&
                   !(flush_i && br_killed(enq_req_i.br_tag, flush_tag_i));
    pop          = skip || (deq_i && head_o.valid);
    head_d       = head_q + PTR_W'(pop);
    tail_d       = tail_q + PTR_W'(push);
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Pointers, occupancy, registered ready and per-entry valid bits.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      enq_ready_q <= 1'b1;
      valid_q     <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      enq_ready_q <= (count_d != CNT_W'(DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_i && valid_q[i] && br_killed(mem_q[i].br_tag, flush_tag_i)) begin
          valid_q[i] <= 1'b0;
        end
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
      end
    end
  end

  // Payload storage.
  always_ff @(posedge clk) begin
    // NOTE: payload is not reset; the reset valid bits already mark every slot empty.
    if (push) begin
      mem_q[tail_q] <= enq_req_i;
    end
  end

  assign enq_ready_o = enq_ready_q;

endmodule

// File: rtl/div_issue_seq.sv
// Issue-side sequencer for the multicycle divider: queues ops, issues one
// at a time, captures the result and holds it for the CDB.
// Optional build macro: DIV_ZERO_BYPASS_EN -- ops with a zero divisor skip
// the divider and produce the RISC-V divide-by-zero result directly.
module div_issue_seq
  import rv32i_types::*;
#(
  parameter int XLEN      = DIV_XLEN,
  parameter int DEPTH     = 4,
  parameter int ROB_IDX_W = DIV_ROB_IDX_W
) (
  input logic            clk,
  input logic            rst,
  div_issue_seq_if.master bus
);

  div_state_e           state_q, state_d;
  div_req_t             inf_q, inf_d;
  logic [XLEN-1:0]      res_data_q, res_data_d;
  logic [ROB_IDX_W-1:0] res_rob_q, res_rob_d;

  div_req_t enq_req;
  div_req_t head;
  logic     fifo_ready;
  logic     deq;
  logic     inf_kill;
  logic     zero_div;
  logic     start;
  logic     taken;
  logic     cdb_valid;

  // Dispatch fields packed into a request entry.
  always_comb begin
    enq_req         = '0;
    enq_req.a       = bus.enq_a;
    enq_req.b       = bus.enq_b;
    enq_req.op      = bus.enq_op;
    enq_req.rob_idx = bus.enq_rob_idx;
    enq_req.br_tag  = bus.enq_br_tag;
    enq_req.valid   = 1'b1;
  end

  div_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .enq_valid_i(bus.enq_valid),
    .enq_req_i  (enq_req),
    .enq_ready_o(fifo_ready),
    .flush_i    (bus.flush),
    .flush_tag_i(bus.flush_tag),
    .deq_i      (deq),
    .head_o     (head)
  );

  // Kill match for the op between issue and CDB grant, and zero-divisor detect.
  always_comb begin
    inf_kill = inf_q.valid && bus.flush && br_killed(inf_q.br_tag, bus.flush_tag);
`ifdef DIV_ZERO_BYPASS_EN
    zero_div = (head.b == '0);
`else
    zero_div = 1'b0;
`endif
  end

  // Sequencer FSM: next state, in-flight/result register updates and strobes.
  always_comb begin
    state_d    = state_q;
    inf_d      = inf_q;
    res_data_d = res_data_q;
    res_rob_d  = res_rob_q;
    deq        = 1'b0;
    start      = 1'b0;
    taken      = 1'b0;
    cdb_valid  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (head.valid) begin
          if (zero_div) begin
            deq        = 1'b1;
            inf_d      = head;
            res_data_d = (head.op == remainder_op) ? XLEN'(head.a) : '1;
            res_rob_d  = head.rob_idx;
            state_d    = ST_HOLD;
          end else if (!bus.div_busy) begin
            deq     = 1'b1;
            inf_d   = head;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (inf_kill) begin
          inf_d.valid = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          start   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (inf_kill) begin
          inf_d.valid = 1'b0;
          state_d     = ST_IDLE;
        end else if (bus.div_done) begin
          taken      = 1'b1;
          res_data_d = bus.div_result;
          res_rob_d  = inf_q.rob_idx;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (inf_kill) begin
          inf_d.valid = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          cdb_valid = 1'b1;
          if (bus.cdb_ready) begin
            inf_d.valid = 1'b0;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, in-flight op and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      inf_q      <= '0;
      res_data_q <= '0;
      res_rob_q  <= '0;
    end else begin
      state_q    <= state_d;
      inf_q      <= inf_d;
      res_data_q <= res_data_d;
      res_rob_q  <= res_rob_d;
    end
  end

  assign bus.enq_ready        = fifo_ready;
  assign bus.div_start        = start;
  assign bus.div_a            = inf_q.a;
  assign bus.div_b            = inf_q.b;
  assign bus.div_type         = inf_q.op;
  assign bus.div_br_tag       = inf_q.br_tag;
  assign bus.div_result_taken = taken;
  assign bus.cdb_valid        = cdb_valid;
  assign bus.cdb_data         = res_data_q;
  assign bus.cdb_rob_idx      = res_rob_q;

endmodule

// File: doc/div_issue_seq.md
# div_issue_seq

Issue-side sequencer for the multicycle divide functional unit. Accepts operand-ready DIV/REM micro-ops from dispatch into a small FIFO, drives the divider's start/operand/tag inputs one op at a time, and captures the completed result. It acknowledges the result with `div_result_taken` and presents it to the CDB with a valid/ready handshake. All queued, in-flight and completed ops are killed on a matching branch flush.

## Interface
Parameters:
- `XLEN`, 32: operand and result width.
- `DEPTH`, 4: request FIFO entries; power of two, at least 2.
- `ROB_IDX_W`, 5: ROB index width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `enq_valid` / `enq_ready`  in / out  1  dispatch handshake; `enq_ready` = FIFO not full.
- `enq_a`, `enq_b`  in  XLEN  dividend, divisor (unsigned).
- `enq_op`  in  1  0 = quotient, 1 = remainder.
- `enq_rob_idx`  in  ROB_IDX_W  destination ROB entry.
- `enq_br_tag`  in  `branch_tag_t`  branch mask of the op.
- `flush`  in  1  branch-mispredict flush.
- `flush_tag`  in  `branch_tag_t`  mispredicted branch mask.
- `div_start`  out  1  single-cycle start pulse to the divider.
- `div_a`, `div_b`  out  XLEN  operands, held stable from start until the result is captured.
- `div_type`  out  1  op select.
- `div_br_tag`  out  `branch_tag_t`  op tag.
- `div_busy`, `div_done`  in  1  divider status.
- `div_result`  in  XLEN  valid when `div_done`.
- `div_result_taken`  out  1  result consumed.
- `cdb_valid`  out  1  result valid to the CDB.
- `cdb_ready`  in  1  CDB grant.
- `cdb_data`  out  XLEN  result value.
- `cdb_rob_idx`  out  ROB_IDX_W  destination ROB entry of the result.

## Operation
- Flush match (function `br_killed(entry_tag, flush_tag)`) is true when either:
  - signs are equal and `(entry.tag & flush.tag) == flush.tag`; or
  - signs differ and `(entry.tag & flush.tag) == entry.tag`.
- FIFO: circular, with head/tail pointers and a count.
  - On `flush`, every valid entry whose tag matches is invalidated in place.
  - The head skips invalid entries at one entry per cycle.
  - An enqueue in a flush cycle is accepted only if its own tag does not match.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE → ISSUE: head entry is valid, `div_busy`=0, and HOLD is not occupied. The entry is popped into the in-flight register (a, b, op, rob_idx, tag).
  - ISSUE: `div_start`=1 for exactly one cycle, then → WAIT.
  - WAIT: when `div_done`=1, assert `div_result_taken`=1 in the same cycle, load the output register, and go → HOLD.
  - HOLD: `cdb_valid`=1. On `cdb_ready`, go → IDLE.
  - HOLD and a new issue never overlap. At most one op is between issue and CDB.
- A matching flush on the in-flight register during ISSUE or WAIT sends the FSM → IDLE, with no capture and no `div_result_taken`; the divider self-clears.
  - The next issue waits for `div_busy`=0.
- A matching flush in HOLD drops `cdb_valid` that cycle and goes → IDLE.
- Flush has priority over `cdb_ready` and `div_done` in the same cycle.
- Reset values:
  - all outputs 0;
  - FIFO empty, so `enq_ready`=1;
  - state IDLE.

## Timing
- Minimum latency: enqueue at cycle 0, issue at cycle 1, `div_start` at cycle 2, then divider latency (18 cycles for the 16-stage unit), `div_done` capture, and `cdb_valid` the next cycle.
- Back-to-back ops: the next `div_start` is no earlier than 2 cycles after the CDB grant, since `div_busy` falls one cycle after `div_result_taken`.
- `enq_ready` is registered from the count. Simultaneous enqueue and dequeue at full is not allowed: the ready signal is already 0.
- Output register is stable while `cdb_valid`=1 and `cdb_ready`=0.

## Configuration
- `DIV_ZERO_BYPASS_EN` defined: an op with `b`==0 skips the divider. In IDLE it goes directly to HOLD with quotient = all ones or remainder = `a`, and no `div_start`. This follows RISC-V divide-by-zero semantics.
- Undefined: every op goes through the divider and the result is whatever the divider returns.

## Structure
- In `rv32i_types`:
  - the existing `branch_tag_t`;
  - `div_req_t` (a, b, op, rob_idx, br_tag, valid);
  - constants `division_op`=0 and `remainder_op`=1;
  - `br_killed` as a package function.
- One sub-module, `div_req_fifo`: the FIFO with flush invalidation and head skip. The FSM and output register sit in the top module.

## Test plan
- Single op a=100, b=7, op=0 → one `div_start` pulse; `cdb_data`=14, `cdb_rob_idx` matches; `div_result_taken` is high for exactly 1 cycle.
- REM a=100, b=7 with `cdb_ready` held 0 for 5 cycles → `cdb_data`=2 stays stable; no second `div_start` until the grant.
- Fill 4 entries → `enq_ready`=0; drain → results appear in FIFO order; `div_start` is never high while `div_busy`=1.
- Flush matching the in-flight op during WAIT → no CDB output for it; the next queued op issues after `div_busy` falls and completes correctly.
- Flush matching entries 1 and 3 of 4 queued → only entries 0 and 2 reach the CDB. A same-cycle enqueue with a matching tag is dropped.
- a=5, b=0, op=0 and op=1 → with the macro: `cdb_data`=0xFFFFFFFF and 5, with no `div_start`. Without the macro: the divider is used.
